lfsr_encryptor: RTL and testbench
=================================

Name: lfsr_encryptor

Overview:
Hardware encryption engine for Program #1 (the encryption direction of the message-cipher flow). It reads a plaintext message and its LFSR configuration from data memory. It prepends pre_length ASCII spaces, XORs each 0x20-offset character with a 7-bit maximal-length LFSR stream, prepends an even-parity bit, and writes 64 ciphertext bytes back to data memory. It sits beside the top-level data memory as a memory-port master, started and acknowledged with the same req/ack handshake as top_level.

Parameters:
MSG_BASE, 0, data memory address of plaintext character 0
MSG_MAX, 61, number of plaintext slots (MSG_BASE..MSG_BASE+MSG_MAX-1)
CFG_BASE, 61, address of pre_length; CFG_BASE+1 = tap pattern, CFG_BASE+2 = LFSR init
OUT_BASE, 64, address of ciphertext byte 0
N_OUT, 64, ciphertext bytes produced per run

Ports:
clk  in  1  system clock, rising-edge
init  in  1  reset, asynchronous, active-low
req  in  1  request; high holds the block idle, a 1->0 transition launches a run
ack  out  1  run complete
busy  out  1  run in progress
mem_addr  out  8  data memory address
mem_rdata  in  8  data memory read data, combinational (same-cycle) read
mem_wdata  out  8  data memory write data
mem_we  out  1  data memory write enable, written on rising clk

Behaviour:
- Reset (init=0, async): state=IDLE, ack=0, busy=0, mem_we=0, mem_addr=0, mem_wdata=0, req_q=1, all internal registers cleared. Reset mid-run aborts immediately. Bytes already written stay in memory; no further writes occur.
- Start detect: req_q registers req each cycle. In IDLE, req_q=1 and req=0 -> LD_LEN. A req held low never relaunches.
- States: IDLE -> LD_LEN -> LD_PTRN -> LD_INIT -> RD -> WR -> (RD | DONE). All transitions are 1 cycle.
  - LD_LEN: mem_addr=CFG_BASE; latch plen=mem_rdata[3:0]; i=0.
  - LD_PTRN: mem_addr=CFG_BASE+1; latch ptrn=mem_rdata[6:0].
  - LD_INIT: mem_addr=CFG_BASE+2; latch lfsr=mem_rdata[6:0]. If that value is 0, load 7'h01.
  - RD: k=i-plen.
    - If i<plen or k>=MSG_MAX, then plain=8'h20 and mem_addr is driven to 0 (read ignored).
    - Otherwise mem_addr=MSG_BASE+k and plain=mem_rdata.
    - Latch c=(plain-8'h20)[6:0]^lfsr.
  - WR: mem_addr=OUT_BASE+i, mem_wdata={^c, c}, mem_we=1. Then lfsr<={lfsr[5:0], ^(lfsr&ptrn)} and i<=i+1. If i==N_OUT-1 -> DONE, else -> RD.
  - DONE: ack=1, busy=0. Stays until req=1 is sampled, then -> IDLE with ack=0 the following cycle.
- busy=1 in every state except IDLE and DONE. mem_we=1 only in WR.
- Subtraction is 8-bit modulo; only bits [6:0] are used. Plaintext bytes <0x20 wrap without error.
- Latency: start detected at edge E0. WR of byte 63 occurs at E0+130; ack=1 after edge E0+131. Exactly 64 writes per run, at ascending addresses OUT_BASE..OUT_BASE+63.
- The block never writes below OUT_BASE and never reads CFG_BASE..CFG_BASE+2 as message data.
- req toggling during a run is ignored. req must be seen high in DONE before the next launch.

Test Plan:
1. ptrn 0x60, init 0x01, plen 10, mem[0]=0x66 ('f') -> mem[64..69]=0x81,0x82,0x84,0x88,0x90,0xA0; mem[70]=0x41; mem[74]=0xDE. ack rises 131 cycles after start detect.
2. Same config but mem[63]=0x00 (zero init) -> identical output to scenario 1 (init forced to 0x01).
3. plen 0, message "four score" padded with 0x20 to 61 bytes -> bytes 61..63 encrypt 0x20, not the config bytes. All 64 outputs match the bench model for each of the 9 tap patterns (0x60, 0x48, 0x78, 0x72, 0x6A, 0x69, 0x5C, 0x7E, 0x7B) with random nonzero init.
4. Round trip with random plen 10..15 -> every output byte has bit7 = XOR of bits[6:0]. Decrypting with the same LFSR and adding 0x20 recovers the padded message exactly.
5. init pulsed low at cycle 40 of a run -> ack=0, busy=0, mem_we=0 immediately. No writes after reset. A new req 1->0 produces a complete, correct run.
6. req held low after DONE -> ack stays 1 with no relaunch. req=1 -> ack=0 next cycle. req 1->0 -> second run produces output identical to the first for the same memory contents.

Source files
------------

// File: rtl/lfsr_encryptor_if.sv
// Handshake and data-memory port bundle for the LFSR encryptor.
// The engine is the memory master; the slave side is the memory plus the launching controller.
interface lfsr_encryptor_if;
  logic       req;
  logic       ack;
  logic       busy;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic [7:0] mem_wdata;
  logic       mem_we;

  modport master (
    input  req, mem_rdata,
    output ack, busy, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    output req, mem_rdata,
    input  ack, busy, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/lfsr_encryptor.sv
// Program #1 encryption engine: pads the plaintext with leading spaces, XORs it with a
// 7-bit LFSR stream, prepends an even-parity bit and writes 64 ciphertext bytes to memory.
module lfsr_encryptor #(
  parameter int unsigned MSG_BASE = 0,
  parameter int unsigned MSG_MAX  = 61,
  parameter int unsigned CFG_BASE = 61,
  parameter int unsigned OUT_BASE = 64,
  parameter int unsigned N_OUT    = 64
) (
  input  logic              clk,
  input  logic              init,
  lfsr_encryptor_if.master  bus
);

  localparam logic [7:0] MSG_BASE8 = 8'(MSG_BASE);
  localparam logic [7:0] MSG_MAX8  = 8'(MSG_MAX);
  localparam logic [7:0] CFG_BASE8 = 8'(CFG_BASE);
  localparam logic [7:0] OUT_BASE8 = 8'(OUT_BASE);
  localparam logic [7:0] LAST_IDX  = 8'(N_OUT - 1);

  typedef enum logic [2:0] {
    IDLE, LD_LEN, LD_PTRN, LD_INIT, RD, WR, DONE
  } state_t;

  state_t     state;
  logic       req_q;
  logic [3:0] plen;
  logic [6:0] ptrn;
  logic [6:0] lfsr;
  logic [7:0] idx;

  logic [7:0] plain;
  logic [7:0] offset;
  logic [6:0] c_next;
  logic [6:0] lfsr_next;

  // Slots before the message (leading padding) and past its end both encrypt a space.
  function automatic logic pad_slot(input logic [7:0] i, input logic [3:0] len);
    logic [7:0] k;
    k = i - {4'd0, len};
    return (i < {4'd0, len}) || (k >= MSG_MAX8);
  endfunction

  function automatic logic [7:0] rd_addr(input logic [7:0] i, input logic [3:0] len);
    return pad_slot(i, len) ? 8'd0 : MSG_BASE8 + (i - {4'd0, len});
  endfunction

  always_comb begin
    plain     = pad_slot(idx, plen) ? 8'h20 : bus.mem_rdata;
    offset    = plain - 8'h20;
    c_next    = offset[6:0] ^ lfsr;
    lfsr_next = {lfsr[5:0], ^(lfsr & ptrn)};
  end

  // Outputs are registered: each state's address is set up on the edge that enters it,
  // so the combinational memory read is valid throughout that state.
  always_ff @(posedge clk or negedge init) begin
    if (!init) begin
      state         <= IDLE;
      req_q         <= 1'b1;
      plen          <= '0;
      ptrn          <= '0;
      lfsr          <= '0;
      idx           <= '0;
      bus.ack       <= 1'b0;
      bus.busy      <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_we    <= 1'b0;
    end else begin
      req_q <= bus.req;
      case (state)
        IDLE: begin
          if (req_q && !bus.req) begin
            state        <= LD_LEN;
            bus.busy     <= 1'b1;
            bus.mem_addr <= CFG_BASE8;
          end
        end
        LD_LEN: begin
          plen         <= bus.mem_rdata[3:0];
          idx          <= '0;
          state        <= LD_PTRN;
          bus.mem_addr <= CFG_BASE8 + 8'd1;
        end
        LD_PTRN: begin
          ptrn         <= bus.mem_rdata[6:0];
          state        <= LD_INIT;
          bus.mem_addr <= CFG_BASE8 + 8'd2;
        end
        LD_INIT: begin
          // An all-zero seed would lock the LFSR, so it is replaced by 1.
          lfsr         <= (bus.mem_rdata[6:0] == 7'd0) ? 7'h01 : bus.mem_rdata[6:0];
          state        <= RD;
          bus.mem_addr <= rd_addr(idx, plen);
        end
        RD: begin
          bus.mem_wdata <= {^c_next, c_next};
          bus.mem_addr  <= OUT_BASE8 + idx;
          bus.mem_we    <= 1'b1;
          state         <= WR;
        end
        WR: begin
          lfsr       <= lfsr_next;
          idx        <= idx + 8'd1;
          bus.mem_we <= 1'b0;
          if (idx == LAST_IDX) begin
            state        <= DONE;
            bus.busy     <= 1'b0;
            bus.ack      <= 1'b1;
            bus.mem_addr <= '0;
          end else begin
            state        <= RD;
            bus.mem_addr <= rd_addr(idx + 8'd1, plen);
          end
        end
        DONE: begin
          if (bus.req) begin
            state   <= IDLE;
            bus.ack <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          bus.busy   <= 1'b0;
          bus.ack    <= 1'b0;
          bus.mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_encryptor.sv
// Directed bench for lfsr_encryptor: behavioural data memory, hand vectors and a cipher model.
module tb_lfsr_encryptor;
  logic clk = 1'b0;
  logic init = 1'b0;
  always #5 clk = ~clk;

  lfsr_encryptor_if bus();

  lfsr_encryptor dut (
    .clk  (clk),
    .init (init),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  int wr_count = 0;
  int bad_wr = 0;

  logic [7:0] src     [0:63];
  logic [7:0] dst     [0:63];
  logic [7:0] exp_out [0:63];
  logic [7:0] pad     [0:63];
  logic [6:0] stream  [0:63];
  logic [6:0] taps    [0:8];

  assign bus.mem_rdata = (bus.mem_addr < 8'd64) ? src[bus.mem_addr[5:0]] : 8'hEE;

  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_count <= wr_count + 1;
      if (bus.mem_addr < 8'd64 || bus.mem_addr > 8'd127) bad_wr <= bad_wr + 1;
      else dst[bus.mem_addr[5:0]] <= bus.mem_wdata;
    end
  end

  task automatic load_cfg(input logic [7:0] plen, input logic [7:0] ptrn, input logic [7:0] seed);
    src[61] = plen;
    src[62] = ptrn;
    src[63] = seed;
  endtask

  task automatic build_model(input int plen, input logic [6:0] ptrn, input logic [6:0] seed);
    logic [6:0] r;
    logic [7:0] d;
    logic [6:0] x;
    r = (seed == 7'd0) ? 7'h01 : seed;
    for (int n = 0; n < 64; n++) begin
      if (n < plen || n - plen >= 61) pad[n] = 8'h20;
      else pad[n] = src[n - plen];
      d = pad[n] - 8'h20;
      x = d[6:0] ^ r;
      exp_out[n] = {^x, x};
      stream[n] = r;
      r = {r[5:0], r[6] ^ r[5] ^ r[4] ^ r[3] ^ r[2] ^ r[1] ^ r[0] ^ (^(r & ~ptrn))};
    end
  endtask

  task automatic compare_model(input string name);
    int bad;
    int first;
    bad = 0;
    first = -1;
    for (int n = 0; n < 64; n++) begin
      if (dst[n] !== exp_out[n]) begin
        bad++;
        if (first < 0) first = n;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d bytes differ, byte %0d got %h expected %h",
               name, bad, first, dst[first], exp_out[first]);
    end
  endtask

  task automatic start_run(input string name);
    @(negedge clk);
    bus.req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_start: got %b expected 1", name, bus.busy);
    end
  endtask

  task automatic run_enc(input string name);
    int w0;
    int n;
    w0 = wr_count;
    start_run(name);
    n = 0;
    while (n < 400) begin
      @(posedge clk);
      n++;
      #1;
      if (bus.ack === 1'b1) break;
    end
    checks++;
    if (n != 131) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles expected 131", name, n);
    end
    checks++;
    if (wr_count - w0 != 64) begin
      errors++;
      $display("FAIL %s writes: got %0d expected 64", name, wr_count - w0);
    end
  endtask

  task automatic test_reset();
    init = 1'b0;
    bus.req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b expected 0", bus.ack); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b expected 0", bus.mem_we); end
    checks++; if (bus.mem_addr !== 8'h00) begin errors++; $display("FAIL rst_addr: got %h expected 00", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 8'h00) begin errors++; $display("FAIL rst_wdata: got %h expected 00", bus.mem_wdata); end
    @(negedge clk);
    init = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || wr_count != 0) begin
      errors++;
      $display("FAIL idle_hold: busy %b writes %0d expected 0 and 0", bus.busy, wr_count);
    end
  endtask

  task automatic test_basic();
    logic [7:0] hand [0:7];
    int at [0:7];
    hand = '{8'h81, 8'h82, 8'h84, 8'h88, 8'h90, 8'hA0, 8'h41, 8'hDE};
    at = '{0, 1, 2, 3, 4, 5, 6, 10};
    for (int i = 0; i < 61; i++) src[i] = 8'h20;
    src[0] = 8'h66;
    load_cfg(8'd10, 8'h60, 8'h01);
    run_enc("basic");
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (dst[at[k]] !== hand[k]) begin
        errors++;
        $display("FAIL basic_byte%0d: got %h expected %h", 64 + at[k], dst[at[k]], hand[k]);
      end
    end
    build_model(10, 7'h60, 7'h01);
    compare_model("basic_model");
  endtask

  task automatic test_taps();
    string s;
    logic [6:0] seed;
    s = "four score";
    for (int i = 0; i < 61; i++) src[i] = (i < s.len()) ? s[i] : 8'h20;
    for (int t = 0; t < 9; t++) begin
      seed = 7'($urandom_range(1, 127));
      load_cfg(8'd0, {1'b0, taps[t]}, {1'b0, seed});
      run_enc($sformatf("taps_%h", taps[t]));
      build_model(0, taps[t], seed);
      compare_model($sformatf("taps_%h_seed_%h", taps[t], seed));
    end
  endtask

  task automatic test_zero_init();
    for (int i = 0; i < 61; i++) src[i] = 8'h20;
    src[0] = 8'h66;
    load_cfg(8'd10, 8'h60, 8'h00);
    run_enc("zero_init");
    checks++;
    if (dst[10] !== 8'hDE || dst[0] !== 8'h81) begin
      errors++;
      $display("FAIL zero_init_hand: got %h %h expected 81 DE", dst[0], dst[10]);
    end
    build_model(10, 7'h60, 7'h01);
    compare_model("zero_init_model");
  endtask

  task automatic test_round_trip();
    int plen;
    int bad_par;
    int bad_dec;
    logic [6:0] tap;
    logic [6:0] seed;
    logic [6:0] x;
    logic [7:0] rec;
    for (int r = 0; r < 2; r++) begin
      plen = int'($urandom_range(10, 15));
      tap = taps[$urandom_range(0, 8)];
      seed = 7'($urandom_range(1, 127));
      for (int i = 0; i < 61; i++) src[i] = 8'($urandom_range(32, 126));
      load_cfg(8'(plen), {1'b0, tap}, {1'b0, seed});
      run_enc($sformatf("trip%0d", r));
      build_model(plen, tap, seed);
      compare_model($sformatf("trip%0d_model", r));
      bad_par = 0;
      bad_dec = 0;
      for (int n = 0; n < 64; n++) begin
        if (dst[n][7] !== ^dst[n][6:0]) bad_par++;
        x = dst[n][6:0] ^ stream[n];
        rec = {1'b0, x} + 8'h20;
        if (rec !== pad[n]) bad_dec++;
      end
      checks++;
      if (bad_par != 0) begin errors++; $display("FAIL trip%0d_parity: got %0d bad bytes expected 0", r, bad_par); end
      checks++;
      if (bad_dec != 0) begin errors++; $display("FAIL trip%0d_decrypt: got %0d bad bytes expected 0", r, bad_dec); end
    end
  endtask

  task automatic test_reset_mid_run();
    int w0;
    for (int i = 0; i < 61; i++) src[i] = 8'(8'h41 + (i % 26));
    load_cfg(8'd12, 8'h48, 8'h35);
    start_run("abort");
    repeat (40) @(posedge clk);
    @(negedge clk);
    #2 init = 1'b0;
    #1;
    checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL abort_ack: got %b expected 0", bus.ack); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL abort_we: got %b expected 0", bus.mem_we); end
    w0 = wr_count;
    bus.req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    init = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (wr_count != w0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet: writes %0d busy %b expected 0 and 0", wr_count - w0, bus.busy);
    end
    run_enc("after_abort");
    build_model(12, 7'h48, 7'h35);
    compare_model("after_abort_model");
  endtask

  task automatic test_done_hold();
    int w0;
    int drops;
    for (int i = 0; i < 61; i++) src[i] = 8'(8'h30 + (i % 10));
    load_cfg(8'd3, 8'h7E, 8'h5A);
    run_enc("hold_first");
    build_model(3, 7'h7E, 7'h5A);
    compare_model("hold_first_model");
    w0 = wr_count;
    drops = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.ack !== 1'b1) drops++;
    end
    checks++;
    if (drops != 0) begin errors++; $display("FAIL hold_ack: got %0d low cycles expected 0", drops); end
    checks++;
    if (wr_count != w0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_relaunch: writes %0d busy %b expected 0 and 0", wr_count - w0, bus.busy);
    end
    @(negedge clk);
    bus.req = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.ack !== 1'b0) begin errors++; $display("FAIL hold_release: ack %b expected 0", bus.ack); end
    run_enc("hold_second");
    compare_model("hold_second_model");
  endtask

  initial begin
    taps = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};
    bus.req = 1'b1;
    for (int i = 0; i < 64; i++) src[i] = 8'h20;
    test_reset();
    test_basic();
    test_taps();
    test_zero_init();
    test_round_trip();
    test_reset_mid_run();
    test_done_hold();
    checks++;
    if (bad_wr != 0) begin errors++; $display("FAIL out_of_range_writes: got %0d expected 0", bad_wr); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, errors %0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end
endmodule
